spi_bus_arbiter: RTL and testbench

//  Shares one SPI master between NREQ requesters. Round-robin grant, per-device

---
 rtl/spi_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_bus_arbiter                                              |
// | Description : Shares one SPI master between NREQ clients. Round-robin      |
// |               grant, per-client active-low chip select, one-cycle start    |
// |               pulse to the master and a minimum CS-high restart gap that   |
// |               is counted in prescaler ticks.                               |
// | Option      : SPI_ARB_TIMEOUT_EN - when defined, a transfer that sees      |
// |               TIMEOUT_TICKS ticks in BUSY without spi_done is aborted      |
// |               (abort pulse, CS released). Undefined: abort is tied low.    |
// | Ports       : clock, reset_n (async, active low), tick (prescaler pulse),  |
// |               req[NREQ] (request levels), grant[NREQ] (one-hot),           |
// |               cs_n[NREQ] (= ~grant), sel[SELW] (current/last winner),      |
// |               spi_start (pulse to master), spi_done (pulse from master),   |
// |               busy (not idle), abort (timeout pulse).                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_bus_arbiter #(
  parameter int NREQ          = 4,
  parameter int SELW          = 2,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            tick,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] cs_n,
  output logic [SELW-1:0] sel,
  output logic            spi_start,
  input  logic            spi_done,
  output logic            busy,
  output logic            abort
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // For GAP_TICKS==0 this wraps to 255, but the GAP state is never entered then.
  localparam logic [7:0] c_gap_last   = 8'(GAP_TICKS - 1);
  localparam state_t     c_after_xfer = (GAP_TICKS == 0) ? S_IDLE : S_GAP;

  generate
    if (NREQ < 2 || NREQ > 8 || SELW != $clog2(NREQ) ||
        GAP_TICKS < 0 || GAP_TICKS > 255 ||
        TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_param
      $error("spi_bus_arbiter: parameter out of range");
    end
  endgenerate

  state_t          r_state, w_state;
  logic [NREQ-1:0] r_grant, w_grant;
  logic [SELW-1:0] r_sel,   w_sel;
  logic [SELW-1:0] r_last,  w_last;
  logic [7:0]      r_gap_cnt, w_gap_cnt;
  logic            r_start, w_start;
  logic            w_any;
  logic [SELW-1:0] w_win;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [7:0] c_to_last = 8'(TIMEOUT_TICKS - 1);
  logic [7:0] r_to_cnt, w_to_cnt;
  logic       r_abort,  w_abort;
`endif

  // Round-robin pick: scan offsets 1..NREQ from the last winner. The loop runs
  // from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    w_any = |req;
    w_win = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[SELW'((int'(r_last) + k) % NREQ)]) begin
        w_win = SELW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  always_comb begin
    w_state   = r_state;
    w_grant   = r_grant;
    w_sel     = r_sel;
    w_last    = r_last;
    w_gap_cnt = r_gap_cnt;
    w_start   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    w_to_cnt  = r_to_cnt;
    w_abort   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant = NREQ'(1) << w_win;
          w_sel   = w_win;
          w_state = S_START;
        end
      end
      S_START: begin
        // Registered so the master sees the pulse one cycle after CS falls.
        w_start = 1'b1;
        w_state = S_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
        w_to_cnt = '0;
`endif
      end
      S_BUSY: begin
        if (spi_done) begin
          w_grant   = '0;
          w_last    = r_sel;
          w_gap_cnt = '0;
          w_state   = c_after_xfer;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tick) begin
          if (r_to_cnt == c_to_last) begin
            w_grant   = '0;
            w_last    = r_sel;
            w_gap_cnt = '0;
            w_abort   = 1'b1;
            w_state   = c_after_xfer;
          end else begin
            w_to_cnt = r_to_cnt + 8'd1;
          end
        end
`endif
      end
      S_GAP: begin
        if (tick) begin
          if (r_gap_cnt == c_gap_last) begin
            w_state = S_IDLE;
          end else begin
            w_gap_cnt = r_gap_cnt + 8'd1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_last    <= SELW'(NREQ - 1);
      r_gap_cnt <= '0;
      r_start   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_abort   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_grant   <= w_grant;
      r_sel     <= w_sel;
      r_last    <= w_last;
      r_gap_cnt <= w_gap_cnt;
      r_start   <= w_start;
`ifdef SPI_ARB_TIMEOUT_EN
      r_to_cnt  <= w_to_cnt;
      r_abort   <= w_abort;
`endif
    end
  end

  assign grant     = r_grant;
  assign cs_n      = ~r_grant;
  assign sel       = r_sel;
  assign spi_start = r_start;
  assign busy      = (r_state != S_IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
  assign abort     = r_abort;
`else
  assign abort     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_bus_arbiter                                           |
// | Description : Self-checking bench for spi_bus_arbiter. A GAP_TICKS=2       |
// |               instance carries most scenarios; a GAP_TICKS=0 instance      |
// |               covers the zero-gap re-grant. Expected grants come from a    |
// |               round-robin model held in the bench.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_bus_arbiter;
  localparam int NREQ = 4;
  localparam int GAP  = 2;
  localparam int TO   = 3;

  logic       clock = 1'b0;
  logic       reset_n, tick, spi_done, done0;
  logic [3:0] req, req0;
  logic [3:0] grant, cs_n, grant_z, cs_n_z;
  logic [1:0] sel, sel_z;
  logic       spi_start, busy, abort, start_z, busy_z, abort_z;

  int n_pass = 0;
  int n_total = 0;
  int model_last;

  spi_bus_arbiter #(.NREQ(NREQ), .SELW(2), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TO)) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .req(req), .grant(grant),
    .cs_n(cs_n), .sel(sel), .spi_start(spi_start), .spi_done(spi_done),
    .busy(busy), .abort(abort));

  spi_bus_arbiter #(.NREQ(NREQ), .SELW(2), .GAP_TICKS(0), .TIMEOUT_TICKS(TO)) dut_z (
    .clock(clock), .reset_n(reset_n), .tick(tick), .req(req0), .grant(grant_z),
    .cs_n(cs_n_z), .sel(sel_z), .spi_start(start_z), .spi_done(done0),
    .busy(busy_z), .abort(abort_z));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Round-robin reference: first set request after the previous winner.
  function automatic int rr_pick(logic [3:0] r, int last);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [11:0] ev(logic [3:0] g, logic [1:0] s, logic st, logic b);
    return {g, ~g, s, st, b};
  endfunction

  function automatic logic [11:0] obs_m();
    return {grant, cs_n, sel, spi_start, busy};
  endfunction

  function automatic logic [11:0] obs_z();
    return {grant_z, cs_n_z, sel_z, start_z, busy_z};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; req = '0; req0 = '0; spi_done = 0; done0 = 0; tick = 0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    step();
    model_last = NREQ - 1;
  endtask

  // Drive spi_done and the gap ticks without checking (used to return to IDLE).
  task automatic finish_xfer(int w);
    spi_done = 1; step(); spi_done = 0;
    repeat (GAP) begin tick = 1; step(); tick = 0; end
    model_last = w;
  endtask

  task automatic test_reset();
    do_reset();
    #3 reset_n = 1'b0;
    #1;
    n_total++;
    if (obs_m() !== ev(4'b0000, 2'd0, 1'b0, 1'b0) || abort !== 1'b0)
      $display("FAIL reset_main: got %b abort=%b want %b abort=0", obs_m(), abort, ev(4'b0000, 2'd0, 1'b0, 1'b0));
    else n_pass++;
    n_total++;
    if (obs_z() !== ev(4'b0000, 2'd0, 1'b0, 1'b0) || abort_z !== 1'b0)
      $display("FAIL reset_zero_gap: got %b want %b", obs_z(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
    else n_pass++;
    @(posedge clock);
    #3 reset_n = 1'b1;
    step();
    n_total++;
    if (obs_m() !== ev(4'b0000, 2'd0, 1'b0, 1'b0))
      $display("FAIL reset_idle_after_release: got %b want %b", obs_m(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
    else n_pass++;
  endtask

  task automatic test_single();
    req = 4'b0001;
    step();
    req = '0;
    n_total++;
    if (obs_m() !== ev(4'b0001, 2'd0, 1'b0, 1'b1))
      $display("FAIL single_grant: got %b want %b", obs_m(), ev(4'b0001, 2'd0, 1'b0, 1'b1));
    else n_pass++;
    step();
    n_total++;
    if (obs_m() !== ev(4'b0001, 2'd0, 1'b1, 1'b1))
      $display("FAIL single_start: got %b want %b", obs_m(), ev(4'b0001, 2'd0, 1'b1, 1'b1));
    else n_pass++;
    step();
    n_total++;
    if (obs_m() !== ev(4'b0001, 2'd0, 1'b0, 1'b1))
      $display("FAIL single_busy: got %b want %b", obs_m(), ev(4'b0001, 2'd0, 1'b0, 1'b1));
    else n_pass++;
    spi_done = 1; step(); spi_done = 0;
    n_total++;
    if (obs_m() !== ev(4'b0000, 2'd0, 1'b0, 1'b1))
      $display("FAIL single_cs_release: got %b want %b", obs_m(), ev(4'b0000, 2'd0, 1'b0, 1'b1));
    else n_pass++;
    repeat (GAP) begin tick = 1; step(); tick = 0; end
    n_total++;
    if (obs_m() !== ev(4'b0000, 2'd0, 1'b0, 1'b0))
      $display("FAIL single_idle: got %b want %b", obs_m(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
    else n_pass++;
    model_last = 0;
  endtask

  task automatic test_round_robin();
    logic [3:0] ord [5];
    ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b0100; ord[3] = 4'b1000; ord[4] = 4'b0001;
    do_reset();
    for (int it = 0; it < 24; it++) begin
      int w;
      logic [3:0] g;
      req = (it < 5) ? 4'b1111 : 4'($urandom_range(1, 15));
      w = rr_pick(req, model_last);
      g = 4'b0001 << w;
      step();
      n_total++;
      if (obs_m() !== ev(g, 2'(w), 1'b0, 1'b1))
        $display("FAIL rr_grant it=%0d req=%b: got %b want %b", it, req, obs_m(), ev(g, 2'(w), 1'b0, 1'b1));
      else n_pass++;
      if (it < 5) begin
        n_total++;
        if (grant !== ord[it]) $display("FAIL rr_order it=%0d: got %b want %b", it, grant, ord[it]);
        else n_pass++;
      end
      if (it >= 5) req = 4'($urandom_range(0, 15));
      step();
      n_total++;
      if (obs_m() !== ev(g, 2'(w), 1'b1, 1'b1))
        $display("FAIL rr_start it=%0d: got %b want %b", it, obs_m(), ev(g, 2'(w), 1'b1, 1'b1));
      else n_pass++;
      for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
        if (it >= 5) req = 4'($urandom_range(0, 15));
        step();
        n_total++;
        if (obs_m() !== ev(g, 2'(w), 1'b0, 1'b1))
          $display("FAIL rr_hold it=%0d: got %b want %b", it, obs_m(), ev(g, 2'(w), 1'b0, 1'b1));
        else n_pass++;
      end
      spi_done = 1; step(); spi_done = 0;
      model_last = w;
      n_total++;
      if (obs_m() !== ev(4'b0000, 2'(w), 1'b0, 1'b1))
        $display("FAIL rr_release it=%0d: got %b want %b", it, obs_m(), ev(4'b0000, 2'(w), 1'b0, 1'b1));
      else n_pass++;
      for (int t = 0; t < GAP; t++) begin
        for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
          if (it >= 5) req = 4'($urandom_range(0, 15));
          step();
          n_total++;
          if (obs_m() !== ev(4'b0000, 2'(w), 1'b0, 1'b1))
            $display("FAIL rr_gap_wait it=%0d: got %b want %b", it, obs_m(), ev(4'b0000, 2'(w), 1'b0, 1'b1));
          else n_pass++;
        end
        tick = 1; step(); tick = 0;
        n_total++;
        if (obs_m() !== ev(4'b0000, 2'(w), 1'b0, (t < GAP - 1)))
          $display("FAIL rr_gap_tick it=%0d t=%0d: got %b want %b", it, t, obs_m(), ev(4'b0000, 2'(w), 1'b0, (t < GAP - 1)));
        else n_pass++;
      end
    end
    req = '0;
  endtask

  task automatic test_drop_and_idle_done();
    int w;
    req = 4'b0010;
    step();
    req = '0;
    n_total++;
    if (obs_m() !== ev(4'b0010, 2'd1, 1'b0, 1'b1))
      $display("FAIL drop_grant: got %b want %b", obs_m(), ev(4'b0010, 2'd1, 1'b0, 1'b1));
    else n_pass++;
    repeat (4) step();
    n_total++;
    if (obs_m() !== ev(4'b0010, 2'd1, 1'b0, 1'b1))
      $display("FAIL drop_hold: got %b want %b", obs_m(), ev(4'b0010, 2'd1, 1'b0, 1'b1));
    else n_pass++;
    finish_xfer(1);
    spi_done = 1; step(); spi_done = 0;
    step();
    n_total++;
    if (obs_m() !== ev(4'b0000, 2'd1, 1'b0, 1'b0))
      $display("FAIL idle_done_ignored: got %b want %b", obs_m(), ev(4'b0000, 2'd1, 1'b0, 1'b0));
    else n_pass++;
    req = 4'b1111;
    w = rr_pick(req, model_last);
    step();
    req = '0;
    n_total++;
    if (grant !== (4'b0001 << w)) $display("FAIL idle_done_next_pick: got %b want %b", grant, 4'b0001 << w);
    else n_pass++;
    step();
    finish_xfer(w);
  endtask

  task automatic test_reset_mid();
    req = 4'b1111;
    step(); step(); step();
    #3 reset_n = 1'b0;
    #1;
    n_total++;
    if (obs_m() !== ev(4'b0000, 2'd0, 1'b0, 1'b0))
      $display("FAIL midreset_async: got %b want %b", obs_m(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
    else n_pass++;
    req = '0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (3) begin
      step();
      n_total++;
      if (obs_m() !== ev(4'b0000, 2'd0, 1'b0, 1'b0))
        $display("FAIL midreset_no_start: got %b want %b", obs_m(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
      else n_pass++;
    end
    req = 4'b1111;
    step();
    req = '0;
    n_total++;
    if (obs_m() !== ev(4'b0001, 2'd0, 1'b0, 1'b1))
      $display("FAIL midreset_first_winner: got %b want %b", obs_m(), ev(4'b0001, 2'd0, 1'b0, 1'b1));
    else n_pass++;
    step();
    finish_xfer(0);
  endtask

  task automatic test_zero_gap();
    req0 = 4'b0100;
    step();
    n_total++;
    if (obs_z() !== ev(4'b0100, 2'd2, 1'b0, 1'b1))
      $display("FAIL zgap_grant: got %b want %b", obs_z(), ev(4'b0100, 2'd2, 1'b0, 1'b1));
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (obs_z() !== ev(4'b0100, 2'd2, 1'b1, 1'b1))
        $display("FAIL zgap_start i=%0d: got %b want %b", i, obs_z(), ev(4'b0100, 2'd2, 1'b1, 1'b1));
      else n_pass++;
      done0 = 1; step(); done0 = 0;
      n_total++;
      if (obs_z() !== ev(4'b0000, 2'd2, 1'b0, 1'b0))
        $display("FAIL zgap_release i=%0d: got %b want %b", i, obs_z(), ev(4'b0000, 2'd2, 1'b0, 1'b0));
      else n_pass++;
      step();
      n_total++;
      if (obs_z() !== ev(4'b0100, 2'd2, 1'b0, 1'b1))
        $display("FAIL zgap_regrant i=%0d: got %b want %b", i, obs_z(), ev(4'b0100, 2'd2, 1'b0, 1'b1));
      else n_pass++;
    end
    req0 = '0;
    step();
    done0 = 1; step(); done0 = 0;
    step();
  endtask

  task automatic test_timeout();
    int w;
    req = 4'b0001;
    w = rr_pick(req, model_last);
    step();
    req = '0;
    step();
`ifdef SPI_ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      tick = 1; step(); tick = 0;
      step();
      n_total++;
      if (obs_m() !== ev(4'b0001, 2'(w), 1'b0, 1'b1) || abort !== 1'b0)
        $display("FAIL to_before i=%0d: got %b abort=%b want %b abort=0", i, obs_m(), abort, ev(4'b0001, 2'(w), 1'b0, 1'b1));
      else n_pass++;
    end
    tick = 1; step(); tick = 0;
    n_total++;
    if (obs_m() !== ev(4'b0000, 2'(w), 1'b0, 1'b1) || abort !== 1'b1)
      $display("FAIL to_abort: got %b abort=%b want %b abort=1", obs_m(), abort, ev(4'b0000, 2'(w), 1'b0, 1'b1));
    else n_pass++;
    step();
    n_total++;
    if (abort !== 1'b0) $display("FAIL to_abort_pulse: got %b want 0", abort);
    else n_pass++;
    repeat (GAP) begin tick = 1; step(); tick = 0; end
    model_last = w;
    req = 4'b0001;
    w = rr_pick(req, model_last);
    step();
    req = '0;
    step();
    repeat (TO - 1) begin tick = 1; step(); tick = 0; end
    tick = 1; spi_done = 1; step(); tick = 0; spi_done = 0;
    n_total++;
    if (obs_m() !== ev(4'b0000, 2'(w), 1'b0, 1'b1) || abort !== 1'b0)
      $display("FAIL to_done_wins: got %b abort=%b want %b abort=0", obs_m(), abort, ev(4'b0000, 2'(w), 1'b0, 1'b1));
    else n_pass++;
    repeat (GAP) begin tick = 1; step(); tick = 0; end
    model_last = w;
`else
    repeat (TO + 3) begin tick = 1; step(); tick = 0; end
    n_total++;
    if (obs_m() !== ev(4'b0001, 2'(w), 1'b0, 1'b1) || abort !== 1'b0)
      $display("FAIL no_timeout: got %b abort=%b want %b abort=0", obs_m(), abort, ev(4'b0001, 2'(w), 1'b0, 1'b1));
    else n_pass++;
    finish_xfer(w);
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop_and_idle_done();
    test_reset_mid();
    test_zero_gap();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
